// File: rtl/sram_arbiter.sv
// Read/write arbiter for a single-port async SRAM; reads win, one turnaround/recovery cycle per write.
// Latency: grants combinational, SRAM pins registered (+1), read data valid +2. Requests hold until granted.
// Optional write-starvation guard compiled in with SRAM_ARB_WR_GUARD_EN.
module sram_arbiter #(
   parameter int ADDR_W    = 20,
   parameter int DATA_W    = 16,
   parameter int WR_STARVE = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_rd_req,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic              o_rd_gnt,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_valid,
   input  logic              i_wr_req,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_wr_gnt,
   output logic [ADDR_W-1:0] o_SRAM_ADDR,
   output logic [DATA_W-1:0] o_SRAM_DQ_out,
   output logic              o_SRAM_DQ_oe,
   input  logic [DATA_W-1:0] i_SRAM_DQ,
   output logic              o_SRAM_WE_N
);

   typedef enum logic [1:0] {
      LAST_IDLE = 2'd0,
      LAST_RD   = 2'd1,
      LAST_WR   = 2'd2
   } last_t;

   last_t last_q;
   last_t last_d;
   logic  starve_blk;
   logic  rd_pend;

   // Reads may follow reads or idle; writes need an idle cycle before them.
   always_comb begin
      o_rd_gnt = 1'b0;
      o_wr_gnt = 1'b0;
      if (!i_rst) begin
         o_rd_gnt = i_rd_req && (last_q != LAST_WR) && !starve_blk;
         o_wr_gnt = i_wr_req && !o_rd_gnt && (last_q == LAST_IDLE);
      end
   end

   always_comb begin
      last_d = LAST_IDLE;
      if (o_rd_gnt) begin
         last_d = LAST_RD;
      end else if (o_wr_gnt) begin
         last_d = LAST_WR;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         last_q <= LAST_IDLE;
      end else begin
         last_q <= last_d;
      end
   end

`ifdef SRAM_ARB_WR_GUARD_EN
   logic [3:0] starve_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || o_wr_gnt || !i_wr_req) begin
         starve_cnt <= '0;
      end else if (o_rd_gnt && (starve_cnt != 4'hF)) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   assign starve_blk = (int'(starve_cnt) >= WR_STARVE);
`else
   logic unused_wr_starve;

   assign starve_blk       = 1'b0;
   assign unused_wr_starve = (WR_STARVE != 0);
`endif

   // SRAM pins drive the granted access for exactly the following cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_SRAM_ADDR   <= '0;
         o_SRAM_DQ_out <= '0;
         o_SRAM_DQ_oe  <= 1'b0;
         o_SRAM_WE_N   <= 1'b1;
      end else if (o_rd_gnt) begin
         o_SRAM_ADDR   <= i_rd_addr;
         o_SRAM_DQ_oe  <= 1'b0;
         o_SRAM_WE_N   <= 1'b1;
      end else if (o_wr_gnt) begin
         o_SRAM_ADDR   <= i_wr_addr;
         o_SRAM_DQ_out <= i_wr_data;
         o_SRAM_DQ_oe  <= 1'b1;
         o_SRAM_WE_N   <= 1'b0;
      end else begin
         o_SRAM_DQ_oe  <= 1'b0;
         o_SRAM_WE_N   <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_pend    <= 1'b0;
         o_rd_valid <= 1'b0;
         o_rd_data  <= '0;
      end else begin
         rd_pend    <= o_rd_gnt;
         o_rd_valid <= rd_pend;
         if (rd_pend) begin
            o_rd_data <= i_SRAM_DQ;
         end
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed vector table, starvation sequence, then random traffic vs a history-based model.
module tb_sram_arbiter;
   localparam int AW   = 20;
   localparam int DW   = 16;
   localparam int WS   = 8;
   localparam int MAXC = 4096;
   localparam int NVEC = 26;

   logic          clk = 1'b0;
   logic          rst;
   logic          rd_req, wr_req;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [DW-1:0] wr_data, dq_in;
   logic          rd_gnt, wr_gnt, rd_valid, dq_oe, we_n;
   logic [DW-1:0] rd_data, dq_out;
   logic [AW-1:0] sram_addr;

   always #5 clk = ~clk;

   sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WR_STARVE(WS)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_rd_req     (rd_req),
      .i_rd_addr    (rd_addr),
      .o_rd_gnt     (rd_gnt),
      .o_rd_data    (rd_data),
      .o_rd_valid   (rd_valid),
      .i_wr_req     (wr_req),
      .i_wr_addr    (wr_addr),
      .i_wr_data    (wr_data),
      .o_wr_gnt     (wr_gnt),
      .o_SRAM_ADDR  (sram_addr),
      .o_SRAM_DQ_out(dq_out),
      .o_SRAM_DQ_oe (dq_oe),
      .i_SRAM_DQ    (dq_in),
      .o_SRAM_WE_N  (we_n)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Per-cycle history: inputs plus the grant the rules call for (0 none, 1 read, 2 write).
   bit            h_rst [MAXC];
   bit            h_wrq [MAXC];
   int            h_kind[MAXC];
   logic [AW-1:0] h_addr[MAXC];
   logic [DW-1:0] h_wdat[MAXC];
   logic [DW-1:0] h_dq  [MAXC];
   logic          e_rd, e_wr;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // Reads granted in a row while a write waits, since that write last gave up or got served.
   function automatic int starve_count(input int c);
      int n = 0;
      for (int k = c - 1; k >= 0; k--) begin
         if (h_rst[k] || !h_wrq[k] || h_kind[k] == 2) return n;
         if (h_kind[k] == 1) n++;
         if (n >= 15) return 15;
      end
      return n;
   endfunction

   function automatic logic [AW-1:0] exp_addr(input int c);
      for (int k = c - 1; k >= 0; k--) begin
         if (h_rst[k]) return '0;
         if (h_kind[k] != 0) return h_addr[k];
      end
      return '0;
   endfunction

   function automatic logic [DW-1:0] exp_dq_out(input int c);
      for (int k = c - 1; k >= 0; k--) begin
         if (h_rst[k]) return '0;
         if (h_kind[k] == 2) return h_wdat[k];
      end
      return '0;
   endfunction

   function automatic logic [DW-1:0] exp_rdata(input int c);
      for (int k = c - 1; k >= 0; k--) begin
         if (h_rst[k]) return '0;
         if (k >= 1 && h_kind[k-1] == 1) return h_dq[k];
      end
      return '0;
   endfunction

   task automatic sample();
      int  last;
      bit  blk;
      bit  ev;
      @(negedge clk);
      e_rd = 1'b0;
      e_wr = 1'b0;
      if (cyc >= 2) begin
         last = h_kind[cyc-1];
         blk  = 1'b0;
`ifdef SRAM_ARB_WR_GUARD_EN
         blk  = (starve_count(cyc) >= WS);
`endif
         e_rd = !rst && rd_req && last != 2 && !blk;
         e_wr = !rst && wr_req && !e_rd && last == 0;
         check("grant", {rd_gnt, wr_gnt}, {e_rd, e_wr});
         check("mutex", rd_gnt & wr_gnt, 0);
         check("bus", {sram_addr, dq_out, dq_oe, we_n},
               {exp_addr(cyc), exp_dq_out(cyc), h_kind[cyc-1] == 2, h_kind[cyc-1] != 2});
         ev = (h_kind[cyc-2] == 1) && !h_rst[cyc-1];
         check("rd", {rd_valid, rd_data}, {ev, exp_rdata(cyc)});
      end
   endtask

   task automatic advance();
      if (cyc >= MAXC - 1) begin
         $display("FAIL cycle_budget cycle=%0d limit=%0d", cyc, MAXC);
         $fatal(1, "cycle budget exhausted");
      end
      h_rst[cyc]  = rst;
      h_wrq[cyc]  = wr_req;
      h_kind[cyc] = e_rd ? 1 : (e_wr ? 2 : 0);
      h_addr[cyc] = e_rd ? rd_addr : wr_addr;
      h_wdat[cyc] = wr_data;
      h_dq[cyc]   = dq_in;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit            rst;
      bit            rd;
      logic [AW-1:0] ra;
      bit            wr;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic [DW-1:0] dq;
      bit            erd;
      bit            ewr;
      logic [AW-1:0] eaddr;
      logic [DW-1:0] edq;
      bit            eoe;
      bit            ewen;
      bit            ev;
      logic [DW-1:0] edata;
   } vec_t;

   vec_t tbl[NVEC];

   function automatic vec_t mk(input bit r, input bit rd, input int ra, input bit wr, input int wa,
                               input int wd, input int dq, input bit erd, input bit ewr,
                               input int ea, input int edq, input bit eoe, input bit ewen,
                               input bit ev, input int ed);
      vec_t v;
      v.rst = r;    v.rd = rd;     v.ra = AW'(ra); v.wr = wr;   v.wa = AW'(wa);
      v.wd = DW'(wd); v.dq = DW'(dq); v.erd = erd; v.ewr = ewr; v.eaddr = AW'(ea);
      v.edq = DW'(edq); v.eoe = eoe; v.ewen = ewen; v.ev = ev; v.edata = DW'(ed);
      return v;
   endfunction

   bit s_rd[30];
   bit s_wr[30];

   initial begin
      int first_wr, rd_before, wr_cnt, rd_cnt;
      rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
      rd_addr = '0; wr_addr = '0; wr_data = '0; dq_in = '0;

      //            rst rd ra      wr wa    wd       dq       erd ewr eaddr   edq     oe wen v ed
      tbl[0]  = mk(1, 1, 'h777,  1, 'h10, 'h9999, 0,       0, 0, 0,      0,      0, 1, 0, 0);
      tbl[1]  = mk(0, 1, 'h123,  0, 0,    0,      0,       1, 0, 0,      0,      0, 1, 0, 0);
      tbl[2]  = mk(0, 0, 0,      0, 0,    0,      'hBEEF,  0, 0, 'h123,  0,      0, 1, 0, 0);
      tbl[3]  = mk(0, 0, 0,      0, 0,    0,      'h1111,  0, 0, 'h123,  0,      0, 1, 1, 'hBEEF);
      tbl[4]  = mk(0, 0, 0,      1, 'h10, 'hAAAA, 0,       0, 1, 'h123,  0,      0, 1, 0, 'hBEEF);
      tbl[5]  = mk(0, 0, 0,      1, 'h11, 'h5555, 0,       0, 0, 'h10,   'hAAAA, 1, 0, 0, 'hBEEF);
      tbl[6]  = mk(0, 0, 0,      1, 'h11, 'h5555, 0,       0, 1, 'h10,   'hAAAA, 0, 1, 0, 'hBEEF);
      tbl[7]  = mk(0, 0, 0,      0, 0,    0,      0,       0, 0, 'h11,   'h5555, 1, 0, 0, 'hBEEF);
      tbl[8]  = mk(0, 0, 0,      0, 0,    0,      0,       0, 0, 'h11,   'h5555, 0, 1, 0, 'hBEEF);
      tbl[9]  = mk(0, 1, 'h200,  1, 'h30, 'h1234, 0,       1, 0, 'h11,   'h5555, 0, 1, 0, 'hBEEF);
      tbl[10] = mk(0, 0, 0,      1, 'h30, 'h1234, 'hCAFE,  0, 0, 'h200,  'h5555, 0, 1, 0, 'hBEEF);
      tbl[11] = mk(0, 0, 0,      1, 'h30, 'h1234, 0,       0, 1, 'h200,  'h5555, 0, 1, 1, 'hCAFE);
      tbl[12] = mk(0, 0, 0,      0, 0,    0,      0,       0, 0, 'h30,   'h1234, 1, 0, 0, 'hCAFE);
      tbl[13] = mk(0, 0, 0,      0, 0,    0,      0,       0, 0, 'h30,   'h1234, 0, 1, 0, 'hCAFE);
      tbl[14] = mk(0, 1, 'h345,  0, 0,    0,      0,       1, 0, 'h30,   'h1234, 0, 1, 0, 'hCAFE);
      tbl[15] = mk(1, 0, 0,      0, 0,    0,      'hDEAD,  0, 0, 'h345,  'h1234, 0, 1, 0, 'hCAFE);
      tbl[16] = mk(0, 0, 0,      0, 0,    0,      0,       0, 0, 0,      0,      0, 1, 0, 0);
      tbl[17] = mk(0, 0, 0,      0, 0,    0,      0,       0, 0, 0,      0,      0, 1, 0, 0);
      tbl[18] = mk(0, 0, 0,      1, 'h40, 'h0F0F, 0,       0, 1, 0,      0,      0, 1, 0, 0);
      tbl[19] = mk(1, 0, 0,      0, 0,    0,      0,       0, 0, 'h40,   'h0F0F, 1, 0, 0, 0);
      tbl[20] = mk(0, 0, 0,      0, 0,    0,      0,       0, 0, 0,      0,      0, 1, 0, 0);
      tbl[21] = mk(0, 1, 'h1,    0, 0,    0,      0,       1, 0, 0,      0,      0, 1, 0, 0);
      tbl[22] = mk(0, 1, 'h2,    0, 0,    0,      'h0A01,  1, 0, 'h1,    0,      0, 1, 0, 0);
      tbl[23] = mk(0, 0, 0,      0, 0,    0,      'h0A02,  0, 0, 'h2,    0,      0, 1, 1, 'h0A01);
      tbl[24] = mk(0, 0, 0,      0, 0,    0,      0,       0, 0, 'h2,    0,      0, 1, 1, 'h0A02);
      tbl[25] = mk(0, 0, 0,      0, 0,    0,      0,       0, 0, 'h2,    0,      0, 1, 0, 'h0A02);

      // Two reset cycles give every registered output a defined starting point.
      for (int i = 0; i < 2; i++) begin
         sample();
         advance();
      end

      for (int i = 0; i < NVEC; i++) begin
         rst = tbl[i].rst; rd_req = tbl[i].rd; rd_addr = tbl[i].ra;
         wr_req = tbl[i].wr; wr_addr = tbl[i].wa; wr_data = tbl[i].wd; dq_in = tbl[i].dq;
         sample();
         check($sformatf("tbl%0d_gnt", i), {rd_gnt, wr_gnt}, {tbl[i].erd, tbl[i].ewr});
         check($sformatf("tbl%0d_bus", i), {sram_addr, dq_out, dq_oe, we_n},
               {tbl[i].eaddr, tbl[i].edq, tbl[i].eoe, tbl[i].ewen});
         check($sformatf("tbl%0d_rd", i), {rd_valid, rd_data}, {tbl[i].ev, tbl[i].edata});
         advance();
      end

      // Continuous contention from idle.
      rst = 1'b0; rd_req = 1'b1; rd_addr = AW'('h55); wr_req = 1'b1; wr_addr = AW'('h66);
      wr_data = DW'('h7777);
      for (int i = 0; i < 30; i++) begin
         dq_in = DW'(i);
         sample();
         s_rd[i] = rd_gnt;
         s_wr[i] = wr_gnt;
         advance();
      end
      first_wr = -1; rd_before = 0; wr_cnt = 0; rd_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         if (s_wr[i]) begin
            wr_cnt++;
            if (first_wr < 0) first_wr = i;
         end
         if (s_rd[i]) begin
            rd_cnt++;
            if (first_wr < 0) rd_before++;
         end
      end
`ifdef SRAM_ARB_WR_GUARD_EN
      check("starve_first_wr", first_wr, WS + 1);
      check("starve_rd_before", rd_before, WS);
      check("starve_resume", {s_rd[WS], s_rd[WS+2], s_rd[WS+3]}, 3'b001);
`else
      check("starve_wr_never", wr_cnt, 0);
      check("starve_rd_all", rd_cnt, 30);
`endif
      rd_req = 1'b0; wr_req = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sample();
         advance();
      end

      // Random traffic: requests held until granted, occasionally abandoned, sporadic resets.
      for (int i = 0; i < 2500; i++) begin
         rst   = ($urandom_range(0, 199) == 0);
         dq_in = DW'($urandom());
         sample();
         advance();
         if (!rd_req || h_kind[cyc-1] == 1) begin
            rd_req  = ($urandom_range(0, 99) < 50);
            rd_addr = AW'($urandom());
         end else if ($urandom_range(0, 99) < 3) begin
            rd_req = 1'b0;
         end
         if (!wr_req || h_kind[cyc-1] == 2) begin
            wr_req  = ($urandom_range(0, 99) < 40);
            wr_addr = AW'($urandom());
            wr_data = DW'($urandom());
         end else if ($urandom_range(0, 99) < 3) begin
            wr_req = 1'b0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 20, SRAM address width.
REQ-002 Parameter DATA_W, default 16, SRAM data width.
REQ-003 Parameter WR_STARVE, default 8, max consecutive read grants while a write waits (guard build only).
REQ-004 i_clk  in  1  sole clock; all logic on rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_rd_req  in  1  frame-decoder read request, held with i_rd_addr until granted.
REQ-007 i_rd_addr  in  ADDR_W  read address.
REQ-008 o_rd_gnt  out  1  read accepted this cycle (combinational).
REQ-009 o_rd_data  out  DATA_W  captured read word.
REQ-010 o_rd_valid  out  1  o_rd_data valid, one-cycle pulse per read.
REQ-011 i_wr_req  in  1  sprite/opacity loader write request, held with address/data until granted.
REQ-012 i_wr_addr  in  ADDR_W  write address.
REQ-013 i_wr_data  in  DATA_W  write word.
REQ-014 o_wr_gnt  out  1  write accepted this cycle (combinational).
REQ-015 o_SRAM_ADDR  out  ADDR_W  registered SRAM address.
REQ-016 o_SRAM_DQ_out  out  DATA_W  registered write data, for the top-level tristate.
REQ-017 o_SRAM_DQ_oe  out  1  registered, 1 = drive io_SRAM_DQ.
REQ-018 i_SRAM_DQ  in  DATA_W  SRAM data bus input.
REQ-019 o_SRAM_WE_N  out  1  registered write enable, active-low.

Function
REQ-020 A transfer shall occur only in a cycle where req and gnt are both 1; o_rd_gnt and o_wr_gnt shall never both be 1.
REQ-021 Internal state LAST ∈ {IDLE, RD, WR} shall record the grant of the previous cycle: RD if o_rd_gnt, WR if o_wr_gnt, else IDLE.
REQ-022 o_rd_gnt shall be 1 iff i_rd_req=1, LAST≠WR, and the starvation block (REQ-027) is not active.
REQ-023 o_wr_gnt shall be 1 iff i_wr_req=1, o_rd_gnt=0, and LAST=IDLE; this yields one bus turnaround cycle after a read and one WE_N recovery cycle between writes.
REQ-024 Read accepted in cycle N: o_SRAM_ADDR=i_rd_addr and o_SRAM_DQ_oe=0 from N+1; i_SRAM_DQ shall be sampled at the end of N+1; o_rd_valid=1 with that data in N+2. Latency is 2 cycles. Throughput is one read per cycle.
REQ-025 Write accepted in cycle N: o_SRAM_ADDR, o_SRAM_DQ_out, o_SRAM_DQ_oe=1, and o_SRAM_WE_N=0 shall be driven for exactly cycle N+1; in N+2, o_SRAM_WE_N=1 and o_SRAM_DQ_oe=0 unless another write was granted.
REQ-026 In a cycle with no grant, o_SRAM_ADDR and o_SRAM_DQ_out shall hold their values, o_SRAM_WE_N=1, and o_SRAM_DQ_oe=0.
REQ-027 Guard build: a 4-bit saturating counter shall increment on each o_rd_gnt while i_wr_req=1. It shall clear on o_wr_gnt or when i_wr_req=0. When the counter is ≥WR_STARVE, read grants shall be blocked until a write is granted.
REQ-028 Both requests with LAST=IDLE and counter below WR_STARVE: read wins.
REQ-029 A request dropped before its grant shall be discarded silently; no state shall change.
REQ-030 Address and data arithmetic: none; pure passthrough at ADDR_W/DATA_W.

Reset
REQ-031 While i_rst=1 at a clock edge:
  - LAST=IDLE, counter=0;
  - o_SRAM_WE_N=1, o_SRAM_DQ_oe=0, o_SRAM_ADDR=0, o_SRAM_DQ_out=0;
  - o_rd_data=0, o_rd_valid=0.
REQ-032 While i_rst=1, o_rd_gnt and o_wr_gnt shall be 0.
REQ-033 Reset mid-operation: the in-flight read's o_rd_valid shall be suppressed, and an in-progress write shall end with WE_N=1 from the edge after i_rst rises.

Configuration
REQ-034 Macro SRAM_ARB_WR_GUARD_EN: when defined, the starvation counter of REQ-027 shall be compiled in.
REQ-035 Without SRAM_ARB_WR_GUARD_EN: strict read priority, no counter, writes may starve indefinitely, and WR_STARVE shall be ignored.

Verification
REQ-036 Single read: rd_req with addr 0x00123 in cycle 1 → gnt in 1, SRAM_ADDR=0x00123 in 2, bus data 0xBEEF sampled → rd_valid=1, rd_data=0xBEEF in 3.
REQ-037 Back-to-back writes: wr_req held with addrs 0x10/0x11, data 0xAAAA/0x5555 from idle → grants in cycles 1 and 3; WE_N low only in cycles 2 and 4; oe=1 only in cycles 2 and 4.
REQ-038 Turnaround: read granted in cycle 1, wr_req rises in 1, rd_req drops in 2 → no grant in 2, wr_gnt in 3; read→write on the bus is never in adjacent cycles.
REQ-039 Starvation, guard build, WR_STARVE=8: rd_req and wr_req continuous → 8 read grants, then 1 idle cycle, then wr_gnt, then reads resume; non-guard build → wr_gnt never.
REQ-040 Reset mid-read: read granted in cycle 1, i_rst=1 in cycle 2 → rd_valid stays 0 in 3; all outputs at reset values from cycle 3.
REQ-041 Contention: both requests from idle → rd_gnt=1, wr_gnt=0 in the same cycle; the mutual-exclusion assertion of REQ-020 holds for the whole run.
